// File: rtl/gate_exerciser.sv
// Self-checking exerciser for a 2-input combinational gate: walks {B,A} through 00..11,
// samples X after a settle interval and reports per-vector mismatches, a count and a pass flag.
module gate_exerciser #(
    parameter int unsigned SETTLE_CYCLES = 2,        // legal range 1..15
    parameter logic [3:0]  EXPECT_TT     = 4'b0001   // bit i = expected X for {B,A} = i
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic       X,
    output logic       A,
    output logic       B,
    output logic       BUSY,
    output logic       DONE,
    output logic       PASS,
    output logic [3:0] ERR_MASK,
    output logic [2:0] FAIL_CNT
);

    typedef enum logic [1:0] {StIdle, StSettle, StCheck, StFinish} state_e;

    state_e     state;
    logic [1:0] index;
    logic [3:0] count;
    logic       mismatch;
    logic [2:0] fail_next;

    // Case inequality so an unknown X from the gate is flagged rather than silently passed.
    always_comb begin
        mismatch  = (X !== EXPECT_TT[index]);
        fail_next = FAIL_CNT + {2'b00, mismatch};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= StIdle;
            index    <= 2'd0;
            count    <= 4'd0;
            A        <= 1'b0;
            B        <= 1'b0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            PASS     <= 1'b0;
            ERR_MASK <= 4'd0;
            FAIL_CNT <= 3'd0;
        end else begin
            DONE <= 1'b0;
            unique case (state)
                StIdle: begin
                    A <= 1'b0;
                    B <= 1'b0;
                    if (START) begin
                        state    <= StSettle;
                        index    <= 2'd0;
                        count    <= 4'd0;
                        ERR_MASK <= 4'd0;
                        FAIL_CNT <= 3'd0;
                        PASS     <= 1'b0;
                        BUSY     <= 1'b1;
                    end
                end
                StSettle: begin
                    if (count == 4'(SETTLE_CYCLES - 1)) begin
                        state <= StCheck;
                    end else begin
                        count <= count + 4'd1;
                    end
                end
                StCheck: begin
                    FAIL_CNT <= fail_next;
                    if (mismatch) begin
                        ERR_MASK[index] <= 1'b1;
                    end
                    if (index == 2'd3) begin
                        // PASS must reflect the fourth check, so it uses the updated count.
                        state <= StFinish;
                        DONE  <= 1'b1;
                        PASS  <= (fail_next == 3'd0);
                        A     <= 1'b0;
                        B     <= 1'b0;
                    end else begin
                        state  <= StSettle;
                        index  <= index + 2'd1;
                        count  <= 4'd0;
                        {B, A} <= index + 2'd1;
                    end
                end
                StFinish: begin
                    state <= StIdle;
                    BUSY  <= 1'b0;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_exerciser.sv
// Randomized bench for gate_exerciser: two instances (default and fast/AND variant) driven
// by a behavioural gate truth table and checked cycle by cycle against an arithmetic model.
module tb_gate_exerciser;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start;
    logic       sel;      // which instance is being exercised
    logic [3:0] tt;       // truth table of the gate wired to the selected instance

    logic       x0, a0, b0, busy0, done0, pass0;
    logic [3:0] mask0;
    logic [2:0] cnt0;
    logic       x1, a1, b1, busy1, done1, pass1;
    logic [3:0] mask1;
    logic [2:0] cnt1;

    assign x0 = tt[{b0, a0}];
    assign x1 = tt[{b1, a1}];

    gate_exerciser u_dut0 (
        .CLK(clk), .RST(rst), .START(start & ~sel), .X(x0),
        .A(a0), .B(b0), .BUSY(busy0), .DONE(done0), .PASS(pass0),
        .ERR_MASK(mask0), .FAIL_CNT(cnt0)
    );

    gate_exerciser #(.SETTLE_CYCLES(1), .EXPECT_TT(4'b1000)) u_dut1 (
        .CLK(clk), .RST(rst), .START(start & sel), .X(x1),
        .A(a1), .B(b1), .BUSY(busy1), .DONE(done1), .PASS(pass1),
        .ERR_MASK(mask1), .FAIL_CNT(cnt1)
    );

    logic       o_a, o_b, o_busy, o_done, o_pass;
    logic [3:0] o_mask;
    logic [2:0] o_cnt;
    assign o_a    = sel ? a1 : a0;
    assign o_b    = sel ? b1 : b0;
    assign o_busy = sel ? busy1 : busy0;
    assign o_done = sel ? done1 : done0;
    assign o_pass = sel ? pass1 : pass0;
    assign o_mask = sel ? mask1 : mask0;
    assign o_cnt  = sel ? cnt1 : cnt0;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int settle_of(input logic d);
        return d ? 1 : 2;
    endfunction

    function automatic logic [3:0] expect_of(input logic d);
        return d ? 4'b1000 : 4'b0001;
    endfunction

    task automatic check_idle_zero(input string tag);
        check({tag, " a"}, 32'(o_a), 0);
        check({tag, " b"}, 32'(o_b), 0);
        check({tag, " busy"}, 32'(o_busy), 0);
        check({tag, " done"}, 32'(o_done), 0);
        check({tag, " pass"}, 32'(o_pass), 0);
        check({tag, " mask"}, 32'(o_mask), 0);
        check({tag, " cnt"}, 32'(o_cnt), 0);
    endtask

    // One full run with random stray START pulses while busy; every cycle is checked.
    task automatic do_run(input logic d, input logic [3:0] gate_tt);
        int s, n, idx, done_checks;
        logic [3:0] bad, m;
        string t;
        sel = d;
        tt  = gate_tt;
        s   = settle_of(d);
        n   = 4 * (s + 1) + 1;          // DONE cycle offset from the START edge
        bad = gate_tt ^ expect_of(d);
        @(posedge clk); #1;
        start = 1'b1;
        for (int k = 1; k <= n + 1; k++) begin
            @(posedge clk); #1;
            start = (k < n) ? ($urandom_range(0, 3) == 0) : 1'b0;
            t = $sformatf("run d%0d tt%h k%0d", d, gate_tt, k);
            idx = (k - 1) / (s + 1);
            done_checks = (k >= n) ? 4 : (k - 1) / (s + 1);
            m = bad & 4'((1 << done_checks) - 1);
            check({t, " a"}, 32'(o_a), (k < n) ? 32'(idx & 1) : 0);
            check({t, " b"}, 32'(o_b), (k < n) ? 32'(idx >> 1) : 0);
            check({t, " busy"}, 32'(o_busy), (k <= n) ? 1 : 0);
            check({t, " done"}, 32'(o_done), (k == n) ? 1 : 0);
            check({t, " mask"}, 32'(o_mask), 32'(m));
            check({t, " cnt"}, 32'(o_cnt), 32'($countones(m)));
            check({t, " pass"}, 32'(o_pass), (k >= n && m == 4'd0) ? 1 : 0);
        end
    endtask

    // Start a run, assert reset somewhere inside vector 2 and confirm a clean abort.
    task automatic do_abort(input logic d, input logic [3:0] gate_tt);
        int s, at;
        string t;
        sel = d;
        tt  = gate_tt;
        s   = settle_of(d);
        at  = 2 * (s + 1) + 1 + $urandom_range(0, s);
        @(posedge clk); #1;
        start = 1'b1;
        for (int k = 1; k <= at; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            check($sformatf("abort d%0d k%0d busy", d, k), 32'(o_busy), 1);
        end
        check($sformatf("abort d%0d vec2 b", d), 32'(o_b), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_idle_zero($sformatf("abort d%0d after rst", d));
        for (int k = 0; k < 24; k++) begin
            @(posedge clk); #1;
            check($sformatf("abort d%0d quiet%0d done", d, k), 32'(o_done), 0);
            check($sformatf("abort d%0d quiet%0d busy", d, k), 32'(o_busy), 0);
            check($sformatf("abort d%0d quiet%0d ab", d, k), 32'({o_b, o_a}), 0);
        end
    endtask

    // START held: runs of 13 busy cycles separated by exactly one idle cycle.
    task automatic do_hold();
        int r;
        string t;
        sel = 1'b0;
        tt  = 4'b0001;
        @(posedge clk); #1;
        start = 1'b1;
        for (int k = 1; k <= 42; k++) begin
            @(posedge clk); #1;
            if (k >= 41) start = 1'b0;
            r = k % 14;
            t = $sformatf("hold k%0d", k);
            check({t, " done"}, 32'(o_done), (r == 13) ? 1 : 0);
            check({t, " busy"}, 32'(o_busy), (r != 0) ? 1 : 0);
            if (r == 13) check({t, " pass"}, 32'(o_pass), 1);
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        sel   = 1'b0;
        tt    = 4'b0001;
        repeat (3) @(posedge clk);
        #1;
        check_idle_zero("reset d0");
        sel = 1'b1;
        #1;
        check_idle_zero("reset d1");
        rst = 1'b0;
        sel = 1'b0;

        do_run(1'b0, 4'b0001);   // NOR: pass
        do_run(1'b0, 4'b1110);   // OR: all four fail
        do_run(1'b0, 4'b0000);   // X tied low: vector 0 fails
        do_run(1'b0, 4'b0001);   // NOR again: results cleared
        do_run(1'b1, 4'b1000);   // AND on fast instance
        do_abort(1'b0, 4'b0001);
        do_abort(1'b1, 4'b1000);
        do_hold();
        for (int i = 0; i < 10; i++) begin
            do_run(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gate_exerciser.md
Name: gate_exerciser

Overview:
- Hardware self-checking exerciser for any 2-input combinational gate (NOR by default).
- On START, drives the four input vectors onto the gate under test in order {B,A} = 00, 01, 10, 11, i.e. A,B = (0,0), (1,0), (0,1), (1,1).
- After a settle interval per vector, samples the gate's output X and compares it with an expected truth table.
- Reports per-vector failures, a failure count and a pass flag. Sits beside the gate primitives as the on-chip counterpart to a stimulus bench.

Parameters:
- SETTLE_CYCLES, 2, cycles each vector is held before X is sampled; legal range 1..15, 0 is illegal.
- EXPECT_TT, 4'b0001, expected X for vector index {B,A}: bit0 = X at 00, bit3 = X at 11. Default is NOR.

Ports:
- CLK  input  1  clock, rising edge
- RST  input  1  reset, synchronous, active-high
- START  input  1  begin a run; sampled only in IDLE
- X  input  1  output of gate under test
- A  output  1  gate input A, registered
- B  output  1  gate input B, registered
- BUSY  output  1  high from the cycle after START is accepted through the FINISH cycle inclusive
- DONE  output  1  one-cycle pulse in the FINISH cycle
- PASS  output  1  1 when the last completed run had zero mismatches; held until the next START
- ERR_MASK  output  4  bit i set when vector i mismatched; held until the next START
- FAIL_CNT  output  3  number of mismatching vectors, 0..4; held until the next START

Behaviour:
- Reset (RST high at a clock edge): state=IDLE, vector index=0, settle count=0. A=0, B=0, BUSY=0, DONE=0, PASS=0, ERR_MASK=0, FAIL_CNT=0. RST has priority over every other input.
- States:
  - IDLE: A=B=0.
  - SETTLE: drive {B,A}=index.
  - CHECK: compare X.
  - FINISH: publish results.
- IDLE -> SETTLE when START=1. On this transition: index=0, count=0, ERR_MASK=0, FAIL_CNT=0, PASS=0.
- SETTLE lasts exactly SETTLE_CYCLES cycles with {B,A}=index, then goes to CHECK.
- CHECK lasts 1 cycle. {B,A} is still held. X is compared with EXPECT_TT[index].
  - On mismatch: set ERR_MASK[index] and increment FAIL_CNT.
  - X of x/z counts as a mismatch in simulation.
  - If index==3, go to FINISH. Otherwise index+1 and return to SETTLE with count=0.
- FINISH lasts 1 cycle. DONE=1. PASS=(FAIL_CNT==0), using the count that already includes the 4th check. A=B=0. Then IDLE.
- Timing: START sampled high at edge of cycle T gives SETTLE starting at T+1, and each vector occupies SETTLE_CYCLES+1 cycles. DONE is high in cycle T+1+4*(SETTLE_CYCLES+1): T+13 for the default, T+9 for SETTLE_CYCLES=1.
- START outside IDLE, including during FINISH, is ignored with no effect on the run.
- START held continuously: a new run begins after exactly one IDLE cycle following FINISH.
- Reset mid-run aborts immediately. All outputs take their reset values, no DONE pulse, and previous results are lost.
- FAIL_CNT cannot wrap (max 4 fits in 3 bits).
- Index wrap: index never exceeds 3; returns to 0 only on a new START.

Test Plan:
- NOR gate wired A,B->X, default params, START pulse at T -> A,B sequence 00,10,01,11, each held 3 cycles. DONE at T+13 only, PASS=1, ERR_MASK=0000, FAIL_CNT=0, BUSY high T+1..T+13.
- OR gate in place of NOR, default EXPECT_TT -> DONE at T+13, PASS=0, ERR_MASK=1111, FAIL_CNT=4.
- X tied to 0 -> ERR_MASK=0001, FAIL_CNT=1, PASS=0. Then reconnect NOR and START again -> results cleared on START, final PASS=1.
- START pulsed again at T+5 during a run; separately, RST asserted during vector index 2 -> the T+5 START has no effect and DONE still at T+13. After RST, all outputs 0 on the next cycle, no DONE pulse, A=B=0.
- SETTLE_CYCLES=1, EXPECT_TT=4'b1000 with an AND gate -> DONE at T+9, PASS=1.
- START held high for 40 cycles -> DONE pulses at T+13, T+27 and T+41 relative to the first accept, with exactly one IDLE cycle between runs.
